// File: rtl/macguffin_mode.sv
// Mode-of-operation engine for the MacGuffin 64-bit block cipher core.
// Sequences one block at a time through the core, applying ECB, CBC-encrypt,
// CTR or OFB chaining per packet. Mode and IV are latched on each packet's
// first beat.
module macguffin_mode #(
  parameter int CTR_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [63:0]      iv,
  input  logic [63:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [63:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [63:0]      c_in_tdata,
  output logic             c_in_tvalid,
  input  logic             c_in_tready,
  input  logic [63:0]      c_out_tdata,
  input  logic             c_out_tvalid,
  output logic             c_out_tready,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, OUT} state_t;

  localparam logic [1:0] M_ECB = 2'b00;
  localparam logic [1:0] M_CBC = 2'b01;
  localparam logic [1:0] M_CTR = 2'b10;
  localparam logic [1:0] M_OFB = 2'b11;

  // Bits of the counter block that increment in CTR mode; the rest stay fixed.
  localparam logic [63:0] CTR_MASK = {64{1'b1}} >> (64 - CTR_W);

  state_t      state;
  logic [63:0] p_reg;
  logic        last_reg;
  logic [1:0]  mode_r;
  logic [63:0] chain;
  logic [63:0] ctr;
  logic        first;

  logic [1:0]  sel_mode;
  logic [63:0] sel_chain;
  logic [63:0] sel_ctr;
  logic [63:0] cin_next;
  logic [63:0] ctr_inc;

  // On the first beat of a packet the fresh mode/iv are used directly, since
  // the latched copies only become valid on the following cycle.
  assign sel_mode  = first ? mode : mode_r;
  assign sel_chain = first ? iv   : chain;
  assign sel_ctr   = first ? iv   : ctr;
  assign ctr_inc   = (ctr & ~CTR_MASK) | ((ctr + 64'd1) & CTR_MASK);

  // Block presented to the core, chosen by chaining mode.
  always_comb begin
    cin_next = s_axis_tdata;
    case (sel_mode)
      M_ECB:   cin_next = s_axis_tdata;
      M_CBC:   cin_next = s_axis_tdata ^ sel_chain;
      M_CTR:   cin_next = sel_ctr;
      M_OFB:   cin_next = sel_chain;
      default: cin_next = s_axis_tdata;
    endcase
  end

  // Control FSM with registered handshake outputs and chaining state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      p_reg         <= '0;
      last_reg      <= 1'b0;
      mode_r        <= M_ECB;
      chain         <= '0;
      ctr           <= '0;
      first         <= 1'b1;
      s_axis_tready <= 1'b1;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      c_in_tdata    <= '0;
      c_in_tvalid   <= 1'b0;
      c_out_tready  <= 1'b0;
      busy          <= 1'b0;
      blk_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axis_tvalid) begin
            p_reg         <= s_axis_tdata;
            last_reg      <= s_axis_tlast;
            c_in_tdata    <= cin_next;
            c_in_tvalid   <= 1'b1;
            s_axis_tready <= 1'b0;
            busy          <= 1'b1;
            state         <= SEND;
            if (first) begin
              mode_r <= mode;
              chain  <= iv;
              ctr    <= iv;
              first  <= 1'b0;
            end
          end
        end
        SEND: begin
          if (c_in_tready) begin
            c_in_tvalid  <= 1'b0;
            c_out_tready <= 1'b1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (c_out_tvalid) begin
            c_out_tready  <= 1'b0;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= last_reg;
            state         <= OUT;
            case (mode_r)
              M_ECB: m_axis_tdata <= c_out_tdata;
              M_CBC: begin
                m_axis_tdata <= c_out_tdata;
                chain        <= c_out_tdata;
              end
              M_CTR: begin
                m_axis_tdata <= p_reg ^ c_out_tdata;
                ctr          <= ctr_inc;
              end
              default: begin
                m_axis_tdata <= p_reg ^ c_out_tdata;
                chain        <= c_out_tdata;
              end
            endcase
          end
        end
        OUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            blk_cnt       <= blk_cnt + CNT_W'(1);
            s_axis_tready <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
            if (last_reg) first <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_macguffin_mode.sv
// Self-checking bench for macguffin_mode with a stand-in core E(x)=~x
// that answers three cycles after accepting a block.
module tb_macguffin_mode;
  localparam int CTR_W = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [1:0]       mode;
  logic [63:0]      iv;
  logic [63:0]      s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic [63:0]      m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic [63:0]      c_in_tdata;
  logic             c_in_tvalid;
  logic             c_in_tready;
  logic [63:0]      c_out_tdata;
  logic             c_out_tvalid;
  logic             c_out_tready;
  logic             busy;
  logic [CNT_W-1:0] blk_cnt;

  int checks = 0;
  int errors = 0;

  macguffin_mode #(.CTR_W(CTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .iv(iv),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .c_in_tdata(c_in_tdata), .c_in_tvalid(c_in_tvalid), .c_in_tready(c_in_tready),
    .c_out_tdata(c_out_tdata), .c_out_tvalid(c_out_tvalid), .c_out_tready(c_out_tready),
    .busy(busy), .blk_cnt(blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in cipher core: inverts the block, 3-cycle latency, shares reset.
  logic [63:0] core_x;
  int          core_cnt;
  logic        core_busy;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_out_tvalid <= 1'b0;
      c_out_tdata  <= '0;
      core_busy    <= 1'b0;
      core_cnt     <= 0;
      core_x       <= '0;
    end else begin
      if (c_out_tvalid && c_out_tready) c_out_tvalid <= 1'b0;
      if (c_in_tvalid && c_in_tready) begin
        core_x    <= c_in_tdata;
        core_cnt  <= 3;
        core_busy <= 1'b1;
      end else if (core_busy) begin
        if (core_cnt == 1) begin
          c_out_tvalid <= 1'b1;
          c_out_tdata  <= ~core_x;
          core_busy    <= 1'b0;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  // Records the last block handed to the core.
  logic [63:0] cin_log;
  always @(posedge clk) begin
    if (c_in_tvalid && c_in_tready) cin_log <= c_in_tdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put_input(input logic [1:0] md, input logic [63:0] ivv,
                           input logic [63:0] p, input logic last);
    int n = 0;
    @(negedge clk);
    mode = md; iv = ivv; s_axis_tdata = p; s_axis_tlast = last; s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_axis_tready) begin
      errors++;
      $display("FAIL put_input timeout: s_axis_tready stuck at 0");
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    check("c_in_tvalid latency", {63'd0, c_in_tvalid}, 64'd1);
  endtask

  task automatic get_output(output logic [63:0] d, output logic l);
    int n = 0;
    @(negedge clk);
    while (!m_axis_tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!m_axis_tvalid) begin
      errors++;
      $display("FAIL get_output timeout: m_axis_tvalid never rose");
    end
    d = m_axis_tdata;
    l = m_axis_tlast;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] iv;
    logic [63:0] p;
    logic        last;
    logic [63:0] exp_cin;
    logic [63:0] exp_out;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [63:0] d, p, e, cin_exp, out_exp, d0;
    logic        l, l0, last;
    logic [1:0]  md;
    logic [63:0] ivr;
    int          exp_cnt;
    int          n;
    // reference model state
    logic        r_first;
    logic [1:0]  r_mode;
    logic [63:0] r_chain, r_ctr;
    logic [31:0] ctr_lo;

    vecs[0] = '{2'b00, 64'h0, 64'h0123456789ABCDEF, 1'b1, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
    vecs[1] = '{2'b01, 64'h00000000FFFFFFFF, 64'h0, 1'b0, 64'h00000000FFFFFFFF, 64'hFFFFFFFF00000000};
    vecs[2] = '{2'b00, 64'hDEADBEEF00000000, 64'h0, 1'b1, 64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF};
    vecs[3] = '{2'b10, 64'h11111111FFFFFFFF, 64'h0, 1'b0, 64'h11111111FFFFFFFF, 64'hEEEEEEEE00000000};
    vecs[4] = '{2'b10, 64'h0, 64'h0, 1'b1, 64'h1111111100000000, 64'hEEEEEEEEFFFFFFFF};
    vecs[5] = '{2'b01, 64'hAAAAAAAAAAAAAAAA, 64'h0, 1'b1, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555};
    vecs[6] = '{2'b11, 64'h5555555555555555, 64'h0, 1'b1, 64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA};

    rst = 1'b0;
    mode = 2'b00; iv = '0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1; c_in_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset s_axis_tready", {63'd0, s_axis_tready}, 64'd1);
    check("reset m_axis_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("reset c_in_tvalid", {63'd0, c_in_tvalid}, 64'd0);
    check("reset c_out_tready", {63'd0, c_out_tready}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset blk_cnt", 64'(blk_cnt), 64'd0);
    check("reset m_axis_tdata", m_axis_tdata, 64'd0);
    rst = 1'b1;

    // Directed vectors: ECB, CBC pair, CTR wrap, CBC->OFB packet boundary.
    for (int i = 0; i < 7; i++) begin
      put_input(vecs[i].mode, vecs[i].iv, vecs[i].p, vecs[i].last);
      get_output(d, l);
      check($sformatf("vec%0d c_in", i), cin_log, vecs[i].exp_cin);
      check($sformatf("vec%0d out", i), d, vecs[i].exp_out);
      check($sformatf("vec%0d tlast", i), {63'd0, l}, {63'd0, vecs[i].last});
      check($sformatf("vec%0d blk_cnt", i), 64'(blk_cnt), 64'(i + 1));
      $display("vec%0d mode=%0d p=%h c_in=%h out=%h last=%0d", i, vecs[i].mode, vecs[i].p, cin_log, d, l);
    end

    // Backpressure: output must hold while the sink stalls.
    m_axis_tready = 1'b0;
    put_input(2'b00, 64'h0, 64'h0F0F0F0F0F0F0F0F, 1'b1);
    n = 0;
    @(negedge clk);
    while (!m_axis_tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    d0 = m_axis_tdata; l0 = m_axis_tlast;
    check("bp first data", d0, 64'hF0F0F0F0F0F0F0F0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp data stable", m_axis_tdata, d0);
      check("bp tlast stable", {63'd0, m_axis_tlast}, {63'd0, l0});
      check("bp m_valid held", {63'd0, m_axis_tvalid}, 64'd1);
      check("bp s_ready low", {63'd0, s_axis_tready}, 64'd0);
      check("bp c_in_valid low", {63'd0, c_in_tvalid}, 64'd0);
    end
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release valid", {63'd0, m_axis_tvalid}, 64'd0);
    check("bp release blk_cnt", 64'(blk_cnt), 64'd8);
    $display("backpressure out=%h last=%0d blk_cnt=%0d", d0, l0, blk_cnt);

    // Reset while waiting on the core, mid-packet.
    put_input(2'b01, 64'h123, 64'h5, 1'b0);
    n = 0;
    @(negedge clk);
    while (!c_out_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reached WAIT", {63'd0, c_out_tready}, 64'd1);
    rst = 1'b0;
    #1;
    check("midrst m_valid", {63'd0, m_axis_tvalid}, 64'd0);
    check("midrst c_in_valid", {63'd0, c_in_tvalid}, 64'd0);
    check("midrst c_out_ready", {63'd0, c_out_tready}, 64'd0);
    check("midrst busy", {63'd0, busy}, 64'd0);
    check("midrst blk_cnt", 64'(blk_cnt), 64'd0);
    check("midrst s_ready", {63'd0, s_axis_tready}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("midrst no output", {63'd0, m_axis_tvalid}, 64'd0);
    end
    put_input(2'b00, 64'h0, 64'h0, 1'b1);
    get_output(d, l);
    check("post-reset ECB out", d, 64'hFFFFFFFFFFFFFFFF);
    check("post-reset blk_cnt", 64'(blk_cnt), 64'd1);
    $display("post-reset ECB out=%h blk_cnt=%0d", d, blk_cnt);

    // Randomized packets against a mode-rule reference model.
    exp_cnt = 1;
    r_first = 1'b1; r_mode = 2'b00; r_chain = '0; r_ctr = '0;
    for (int t = 0; t < 60; t++) begin
      md   = 2'($urandom_range(0, 3));
      ivr  = {$urandom, $urandom};
      p    = {$urandom, $urandom};
      last = ($urandom_range(0, 3) == 0);
      if (t % 11 == 5) ivr[31:0] = 32'hFFFFFFFE;
      if (r_first) begin
        r_mode = md; r_chain = ivr; r_ctr = ivr; r_first = 1'b0;
      end
      case (r_mode)
        2'b00: cin_exp = p;
        2'b01: cin_exp = p ^ r_chain;
        2'b10: cin_exp = r_ctr;
        default: cin_exp = r_chain;
      endcase
      e = ~cin_exp;
      out_exp = (r_mode[1]) ? (p ^ e) : e;
      if (r_mode == 2'b01 || r_mode == 2'b11) r_chain = e;
      if (r_mode == 2'b10) begin
        ctr_lo = r_ctr[31:0] + 32'd1;
        r_ctr = {r_ctr[63:32], ctr_lo};
      end
      if (last) r_first = 1'b1;
      exp_cnt++;

      put_input(md, ivr, p, last);
      get_output(d, l);
      check($sformatf("rnd%0d c_in", t), cin_log, cin_exp);
      check($sformatf("rnd%0d out", t), d, out_exp);
      check($sformatf("rnd%0d tlast", t), {63'd0, l}, {63'd0, last});
      check($sformatf("rnd%0d blk_cnt", t), 64'(blk_cnt), 64'(exp_cnt));
      $display("rnd%0d mode=%0d p=%h c_in=%h out=%h last=%0d", t, r_mode, p, cin_log, d, l);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/macguffin_mode.md
Name: macguffin_mode

Overview:
- Block-cipher mode-of-operation engine placed in front of the MacGuffin 64-bit cipher core.
- Accepts 64-bit plaintext beats on AXI-stream and drives the core through a core-side AXI-stream pair.
- Applies ECB, CBC-encrypt, CTR or OFB chaining per packet, with run-time mode and IV selection.
- Emits result beats on AXI-stream with tlast preserved; one block is in flight at a time.

Parameters:
CTR_W, 32, number of low IV bits used as the CTR-mode counter (1..64); upper 64-CTR_W bits are fixed.
CNT_W, 16, width of the processed-block counter blk_cnt.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
mode  in  2  00 ECB, 01 CBC-encrypt, 10 CTR, 11 OFB; sampled on the first beat of each packet
iv  in  64  initial chaining value / counter block; sampled on the first beat of each packet
s_axis_tdata  in  64  input block
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last block of packet
m_axis_tdata  out  64  output block
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  copy of the captured s_axis_tlast
c_in_tdata  out  64  block sent to the cipher core
c_in_tvalid  out  1  core input valid
c_in_tready  in  1  core input ready
c_out_tdata  in  64  core result E(x)
c_out_tvalid  in  1  core result valid
c_out_tready  out  1  core result ready
busy  out  1  high whenever state != IDLE
blk_cnt  out  CNT_W  blocks completed since reset, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=0, async): state=IDLE; s_axis_tready=1; all other outputs 0; first=1; chain=0; ctr=0. The core shares the same reset at top level.
- FSM states: IDLE, SEND, WAIT, OUT.
- IDLE:
  - s_axis_tready=1.
  - On an s handshake: capture P and tlast, go to SEND.
  - If first=1: latch mode into mode_r, load chain=iv and ctr=iv, clear first.
- SEND:
  - c_in_tvalid=1; c_in_tdata is registered and held stable until c_in_tready.
  - c_in_tdata by mode: ECB=P; CBC=P^chain; CTR=ctr; OFB=chain.
  - On the handshake, go to WAIT.
- WAIT:
  - c_out_tready=1.
  - On the handshake with E=c_out_tdata, register m_axis_tdata by mode: ECB=E; CBC=E; CTR=P^E; OFB=P^E.
  - Update chain: CBC and OFB take chain=E.
  - Update counter: CTR takes ctr[CTR_W-1:0]+1 modulo 2^CTR_W; ctr[63:CTR_W] is unchanged.
  - Go to OUT next cycle.
- OUT:
  - m_axis_tvalid=1; data and tlast held stable while tready=0.
  - On the handshake: blk_cnt+=1; if tlast=1, set first=1; go to IDLE.
- s_axis_tready is 0 in SEND, WAIT and OUT. No input is accepted until the previous result is delivered.
- Latency with a zero-wait core and sink: s handshake at cycle t gives c_in_tvalid at t+1, and m_axis_tvalid 1 cycle after the core result handshake.
- mode and iv changes mid-packet are ignored until the next first beat.
- A core result arriving outside WAIT is not accepted (c_out_tready=0).
- Reset mid-operation:
  - The in-flight block is discarded and no partial output appears.
  - Chaining restarts from iv on the next beat.

Test Plan:
Bench core model: E(x)=~x, 3-cycle latency.
1. ECB, P=0x0123456789ABCDEF -> c_in_tdata=0x0123456789ABCDEF; m_axis_tdata=0xFEDCBA9876543210; blk_cnt=1.
2. CBC, iv=0x00000000FFFFFFFF, P0=P1=0 (tlast on P1):
   - c_in0=0x00000000FFFFFFFF, C0=0xFFFFFFFF00000000.
   - c_in1=0xFFFFFFFF00000000, C1=0x00000000FFFFFFFF; m_axis_tlast=1 on C1 only.
3. CTR, CTR_W=32, iv=0x11111111FFFFFFFF, P0=P1=0:
   - c_in0=0x11111111FFFFFFFF, c_in1=0x1111111100000000 (wrap, upper bits kept).
   - Outputs 0xEEEEEEEE00000000 then 0xEEEEEEEEFFFFFFFF.
4. Packet boundary:
   - CBC single beat with tlast, iv=0xAAAA...AA. Then OFB packet, iv=0x5555...55, P=0.
   - c_in of the second packet = 0x5555555555555555; output = 0xAAAAAAAAAAAAAAAA.
5. Backpressure: hold m_axis_tready=0 for 10 cycles in OUT -> m_axis_tdata/tlast stable, s_axis_tready=0, c_in_tvalid=0; completes on release.
6. Assert rst=0 during WAIT:
   - Immediately: all valids=0, busy=0, blk_cnt=0, s_axis_tready=1.
   - Next ECB block P=0 gives 0xFFFFFFFFFFFFFFFF.
